// File: rtl/excess3_pkg.sv
// Shared excess-3 code constants and the legality test used by the digit converter.
package excess3_pkg;

    localparam logic [3:0] E3_OFFSET = 4'd3;
    localparam logic [3:0] E3_MIN    = 4'b0011;
    localparam logic [3:0] E3_MAX    = 4'b1100;

    function automatic logic e3_is_legal(input logic [3:0] digit);
        return (digit >= E3_MIN) && (digit <= E3_MAX);
    endfunction

endpackage

// File: rtl/excess3_digit.sv
// Combinational single-digit excess-3 to BCD conversion with illegal-code flag.
module excess3_digit
    import excess3_pkg::*;
(
    input  logic [3:0] e3,
    output logic [3:0] bcd,
    output logic       err
);

    // Illegal codes produce a clean zero digit rather than a wrapped difference.
    always_comb begin
        err = !e3_is_legal(e3);
        bcd = err ? 4'b0000 : (e3 - E3_OFFSET);
    end

endmodule

// File: rtl/excess_3_to_bcd.sv
// Registered packed excess-3 to BCD converter with per-digit error flags,
// a sticky error bit and a saturating count of erroring words.
module excess_3_to_bcd
    import excess3_pkg::*;
#(
    parameter int DIGITS = 1,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [4*DIGITS-1:0]   a,
    input  logic                  clr_err,
    output logic [4*DIGITS-1:0]   b,
    output logic                  out_valid,
    output logic [DIGITS-1:0]     digit_err,
    output logic                  err_sticky,
    output logic [CNT_W-1:0]      err_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic [4*DIGITS-1:0] bcd_p0;
    logic [DIGITS-1:0]   err_p0;
    logic                vld_p0;

    logic [4*DIGITS-1:0] b_p1;
    logic [DIGITS-1:0]   err_p1;
    logic                vld_p1;
    logic                sticky_p1;
    logic [CNT_W-1:0]    cnt_p1;

    assign vld_p0 = in_valid;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        excess3_digit u_digit (
            .e3  (a[4*i +: 4]),
            .bcd (bcd_p0[4*i +: 4]),
            .err (err_p0[i])
        );
    end

    // ---- stage p0 -> p1: output register, data held while no valid word ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            b_p1   <= '0;
            err_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                b_p1   <= bcd_p0;
                err_p1 <= err_p0;
            end
        end
    end

    // Clear has priority over a simultaneous erroring word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p1    <= '0;
            sticky_p1 <= 1'b0;
        end else if (clr_err) begin
            cnt_p1    <= '0;
            sticky_p1 <= 1'b0;
        end else if (vld_p0 && (|err_p0)) begin
            cnt_p1    <= sat_inc(cnt_p1);
            sticky_p1 <= 1'b1;
        end
    end

    assign b          = b_p1;
    assign out_valid  = vld_p1;
    assign digit_err  = err_p1;
    assign err_sticky = sticky_p1;
    assign err_count  = cnt_p1;

endmodule

// File: tb/tb_excess_3_to_bcd.sv
// Directed self-checking bench: single-digit instance (4-bit counter) and two-digit instance.
module tb_excess_3_to_bcd;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       in_valid1 = 1'b0;
    logic [3:0] a1 = '0;
    logic       clr1 = 1'b0;
    logic [3:0] b1;
    logic       vld1;
    logic [0:0] derr1;
    logic       stk1;
    logic [3:0] cnt1;

    logic        in_valid2 = 1'b0;
    logic [7:0]  a2 = '0;
    logic        clr2 = 1'b0;
    logic [7:0]  b2;
    logic        vld2;
    logic [1:0]  derr2;
    logic        stk2;
    logic [15:0] cnt2;

    int asserts = 0;
    int fails = 0;

    always #5 clk = ~clk;

    excess_3_to_bcd #(.DIGITS(1), .CNT_W(4)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .a(a1), .clr_err(clr1),
        .b(b1), .out_valid(vld1), .digit_err(derr1), .err_sticky(stk1), .err_count(cnt1)
    );

    excess_3_to_bcd #(.DIGITS(2), .CNT_W(16)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .a(a2), .clr_err(clr2),
        .b(b2), .out_valid(vld2), .digit_err(derr2), .err_sticky(stk2), .err_count(cnt2)
    );

    typedef struct {
        logic       vld;
        logic [3:0] a;
        logic       clr;
        logic [3:0] eb;
        logic       evld;
        logic       ederr;
        logic [3:0] ecnt;
        logic       estk;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [3:0] av, input logic c, input logic [3:0] eb,
                       input logic ev, input logic ed, input logic [3:0] ec, input logic es);
        vec_t t;
        t.vld = v; t.a = av; t.clr = c; t.eb = eb; t.evld = ev; t.ederr = ed; t.ecnt = ec; t.estk = es;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive1(input logic v, input logic [3:0] av, input logic c);
        @(negedge clk);
        in_valid1 = v; a1 = av; clr1 = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic [3:0] eb, input logic ev, input logic ed,
                        input logic [3:0] ec, input logic es);
        check({tag, ".b"}, 32'(b1), 32'(eb));
        check({tag, ".out_valid"}, 32'(vld1), 32'(ev));
        check({tag, ".digit_err"}, 32'(derr1), 32'(ed));
        check({tag, ".err_count"}, 32'(cnt1), 32'(ec));
        check({tag, ".err_sticky"}, 32'(stk1), 32'(es));
    endtask

    task automatic drive2(input logic v, input logic [7:0] av);
        @(negedge clk);
        in_valid2 = v; a2 = av;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Sweep of every legal code: 0011..1100 -> 0..9
        for (int i = 0; i < 10; i++)
            add(1'b1, 4'(i + 3), 1'b0, 4'(i), 1'b1, 1'b0, 4'd0, 1'b0);
        add(1'b1, 4'b0000, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1);
        add(1'b1, 4'b0010, 1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b1);
        add(1'b1, 4'b1101, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b1);
        add(1'b1, 4'b1111, 1'b0, 4'd0, 1'b1, 1'b1, 4'd4, 1'b1);
        add(1'b1, 4'b0111, 1'b0, 4'd4, 1'b1, 1'b0, 4'd4, 1'b1);
        for (int i = 0; i < 3; i++)
            add(1'b0, 4'b0011, 1'b0, 4'd4, 1'b0, 1'b0, 4'd4, 1'b1);
        add(1'b1, 4'b1110, 1'b0, 4'd0, 1'b1, 1'b1, 4'd5, 1'b1);
        add(1'b0, 4'b0100, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1);
        add(1'b1, 4'b0001, 1'b1, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        add(1'b1, 4'b1001, 1'b0, 4'd6, 1'b1, 1'b0, 4'd0, 1'b0);

        // Reset held with a valid word present
        rst_n = 1'b0;
        in_valid1 = 1'b1; a1 = 4'b1000;
        in_valid2 = 1'b1; a2 = 8'h88;
        repeat (3) @(posedge clk);
        #1;
        chk1("reset", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        check("reset.d2.b", 32'(b2), 32'h0);
        check("reset.d2.out_valid", 32'(vld2), 32'h0);
        check("reset.d2.err_count", 32'(cnt2), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk1("first", 4'd5, 1'b1, 1'b0, 4'd0, 1'b0);
        check("first.d2.b", 32'(b2), 32'h55);

        @(negedge clk);
        in_valid1 = 1'b0; in_valid2 = 1'b0;

        foreach (vecs[i]) begin
            drive1(vecs[i].vld, vecs[i].a, vecs[i].clr);
            chk1($sformatf("vec%0d", i), vecs[i].eb, vecs[i].evld, vecs[i].ederr, vecs[i].ecnt, vecs[i].estk);
        end

        // Saturation of the 4-bit counter over 17 illegal words
        for (int i = 0; i < 17; i++) begin
            drive1(1'b1, 4'b1101, 1'b0);
            check($sformatf("sat%0d.err_count", i), 32'(cnt1), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end
        check("sat.err_sticky", 32'(stk1), 32'h1);

        // Clear with no word in flight leaves data outputs alone
        drive1(1'b1, 4'b1100, 1'b0);
        chk1("preclr", 4'd9, 1'b1, 1'b0, 4'd15, 1'b1);
        drive1(1'b0, 4'b0000, 1'b1);
        chk1("clr", 4'd9, 1'b0, 1'b0, 4'd0, 1'b0);
        drive1(1'b0, 4'b0000, 1'b0);

        // Two-digit words
        drive2(1'b1, 8'b1100_0011);
        check("d2.w0.b", 32'(b2), 32'h90);
        check("d2.w0.digit_err", 32'(derr2), 32'b00);
        check("d2.w0.err_count", 32'(cnt2), 32'd0);
        drive2(1'b1, 8'b1111_0110);
        check("d2.w1.b", 32'(b2), 32'h03);
        check("d2.w1.digit_err", 32'(derr2), 32'b10);
        check("d2.w1.err_count", 32'(cnt2), 32'd1);
        check("d2.w1.err_sticky", 32'(stk2), 32'h1);
        drive2(1'b1, 8'h2D);
        check("d2.w2.b", 32'(b2), 32'h00);
        check("d2.w2.digit_err", 32'(derr2), 32'b11);
        check("d2.w2.err_count", 32'(cnt2), 32'd2);
        drive2(1'b1, 8'h5A);
        check("d2.w3.b", 32'(b2), 32'h27);
        check("d2.w3.digit_err", 32'(derr2), 32'b00);
        check("d2.w3.out_valid", 32'(vld2), 32'h1);
        check("d2.w3.err_count", 32'(cnt2), 32'd2);

        // Reset mid-stream drops the in-flight word
        @(negedge clk);
        in_valid2 = 1'b1; a2 = 8'h44;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.out_valid", 32'(vld2), 32'h0);
        check("midrst.b", 32'(b2), 32'h0);
        @(negedge clk);
        in_valid2 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst.out_valid", 32'(vld2), 32'h0);
        check("postrst.err_count", 32'(cnt2), 32'd0);
        drive2(1'b1, 8'h44);
        check("postrst.b", 32'(b2), 32'h11);
        check("postrst.out_valid2", 32'(vld2), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/excess_3_to_bcd.md
Name: excess_3_to_bcd

Overview:
- Registered converter from packed excess-3 digits to packed BCD digits (out = in − 3 per digit).
- Flags illegal excess-3 codes per digit and keeps a saturating error counter.
- Sits between an excess-3 source (keypad/display-side logic) and BCD arithmetic or display blocks.
- Single clock domain, one-cycle latency, valid-qualified stream, no backpressure.

Parameters:
- DIGITS, 1, number of 4-bit digits converted in parallel (1..8).
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  a carries a word to convert this cycle
- a  input  4*DIGITS  packed excess-3 input; digit i = a[4i+3:4i]
- clr_err  input  1  synchronous clear of err_count and err_sticky
- b  output  4*DIGITS  packed BCD result; digit i = b[4i+3:4i]
- out_valid  output  1  b/digit_err valid this cycle
- digit_err  output  DIGITS  per-digit illegal-code flag for the word on b
- err_sticky  output  1  set when any illegal digit has been accepted since reset/clear
- err_count  output  CNT_W  count of accepted words containing ≥1 illegal digit, saturating

Behaviour:
- Reset (rst_n low, asynchronous): b=0, out_valid=0, digit_err=0, err_sticky=0, err_count=0; held until rst_n rises; first capture on the first rising clk edge with rst_n high.
- Per digit, legal codes 0011..1100 map to BCD 0000..1001 (value − 3, mod-16 arithmetic, no borrow between digits).
- Illegal codes 0000, 0001, 0010, 1101, 1110, 1111: BCD digit forced to 0000 and that digit's digit_err bit set; other digits unaffected.
- Latency 1: when in_valid=1 at edge N, b, digit_err and out_valid=1 are presented after edge N and hold until the next edge.
- in_valid=0 at an edge: out_valid=0 next cycle; b and digit_err hold their last values (not cleared).
- Back-to-back valid words each produce one output cycle; no stalls, no backpressure.
- err_count increments by 1 per accepted word with any digit_err bit; saturates at all-ones and never wraps.
- err_sticky sets on the same edge as the counter increment.
- clr_err=1 at an edge zeroes err_count and err_sticky. If an erroring word is accepted on that same edge, clear wins: result is 0, not 1. clr_err does not affect b, out_valid or digit_err.
- Reset asserted mid-stream drops any in-flight word; no output after release until a new in_valid.
- Inputs with X are not required to be handled; behaviour is defined only for 0/1 values.

Decomposition:
- Package excess3_pkg holds:
  - E3_OFFSET = 4'd3
  - E3_MIN = 4'b0011
  - E3_MAX = 4'b1100
  - function e3_is_legal(digit)
- Natural sub-module: excess3_digit. Combinational, 4-bit in → 4-bit BCD out plus err flag; instantiated DIGITS times via generate.
- The top module holds all registers, the counter and the sticky flag.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and a=4'b1000 over several edges → b=0, out_valid=0, err_count=0. Release reset → first conversion one cycle after the first valid edge.
- Full legal sweep (DIGITS=1): a = 0011,0100,…,1100 on consecutive cycles with in_valid=1 → b = 0000,0001,…,1001 one cycle later, out_valid=1 continuously, digit_err=0, err_count unchanged.
- Illegal codes (DIGITS=1): a = 0000,0010,1101,1111 → each gives b=0000, digit_err=1. err_count goes 1,2,3,4; err_sticky=1 after the first.
- Multi-digit (DIGITS=2): a=8'b1100_0011 → b=8'h90, digit_err=2'b00. Then a=8'b1111_0110 → b=8'h03, digit_err=2'b10, err_count+1.
- Valid gap and clear:
  - in_valid=0 for 3 cycles → out_valid=0 and b holds its last value.
  - clr_err=1 on the same edge as an illegal word → err_count=0, err_sticky=0, digit_err=1 for that word.
- Saturation (CNT_W=4): 17 illegal words → err_count stops at 15.
